// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data beats fetch, fetch wins after STARVE_MAX data grants; LATENCY+3 cycles per access.
// No backpressure on the memory side; requesters hold req until their ready pulse, stall_* freeze the pipeline meanwhile.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              stall_if,
  output logic              stall_d,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WC_W = $clog2(LATENCY + 1);
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              owner_d;
  logic [WC_W-1:0]   wait_cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic              any_req, grant_d, last_wait;

  assign any_req   = if_req | d_req;
  assign grant_d   = d_req & (~if_req | (starve_cnt != SC_W'(STARVE_MAX)));
  assign last_wait = (state_q == WAIT) && (wait_cnt == WC_W'(1));

  assign stall_if = if_req & ~if_ready;
  assign stall_d  = d_req & ~d_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (last_wait) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_d    <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      busy     <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_d   <= grant_d;
            mem_en    <= 1'b1;
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_we    <= grant_d & d_we;
            mem_wdata <= grant_d ? d_wdata : '0;
            // Count only data grants that made a waiting fetch lose.
            if (grant_d && if_req) begin
              if (starve_cnt != SC_W'(STARVE_MAX)) starve_cnt <= starve_cnt + SC_W'(1);
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        ISSUE: wait_cnt <= WC_W'(LATENCY);
        WAIT: begin
          wait_cnt <= wait_cnt - WC_W'(1);
          if (last_wait) begin
            if (owner_d) begin
              if (!mem_we) d_rdata <= mem_rdata;
              d_ready <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors, starvation/reset/latency-1 sequences, then random traffic vs. a transaction model.
module tb_mem_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;

  logic [31:0] if_rdata0, d_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic        if_ready0, d_ready0, stall_if0, stall_d0, busy0, mem_en0, mem_we0;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_ready1, d_ready1, stall_if1, stall_d1, busy1, mem_en1, mem_we1;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata0), .if_ready(if_ready0),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata0), .d_ready(d_ready0),
    .stall_if(stall_if0), .stall_d(stall_d0), .busy(busy0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .STARVE_MAX(SMAX)) u_dut_lat1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata1), .d_ready(d_ready1),
    .stall_if(stall_if1), .stall_d(stall_d1), .busy(busy1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural memories: return data only in the exact cycle it is due, junk otherwise.
  logic [31:0] mem0 [logic [31:0]];
  logic [31:0] mem1 [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F17;
  endfunction
  function automatic logic [31:0] rd0(input logic [31:0] a);
    return mem0.exists(a) ? mem0[a] : dflt(a);
  endfunction
  function automatic logic [31:0] rd1(input logic [31:0] a);
    return mem1.exists(a) ? mem1[a] : dflt(a);
  endfunction

  int          cyc = 0;
  int          pend0_cyc = -1, pend1_cyc = -1;
  logic [31:0] pend0_dat = '0, pend1_dat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en0) begin
      if (mem_we0) mem0[mem_addr0] = mem_wdata0;
      else begin
        pend0_cyc <= cyc + LAT;
        pend0_dat <= rd0(mem_addr0);
      end
    end
    if (mem_en1) begin
      if (mem_we1) mem1[mem_addr1] = mem_wdata1;
      else begin
        pend1_cyc <= cyc + 1;
        pend1_dat <= rd1(mem_addr1);
      end
    end
  end

  assign mem_rdata0 = (cyc == pend0_cyc) ? pend0_dat : (32'hBAD0_0000 ^ 32'(cyc));
  assign mem_rdata1 = (cyc == pend1_cyc) ? pend1_dat : (32'hBAD1_0000 ^ 32'(cyc));

  typedef struct {
    logic        fetch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [4];

  task automatic idle_inputs();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Request issued in cycle k (t=0); grant k+1, ready k+4, idle again k+5.
  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    if (v.fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk1("vec_mem_en", mem_en0, t == 1);
      chk1("vec_busy", busy0, t >= 1);
      chk1("vec_if_ready", if_ready0, v.fetch && t == 4);
      chk1("vec_d_ready", d_ready0, !v.fetch && t == 4);
      chk1("vec_stall_if", stall_if0, v.fetch && t < 4);
      chk1("vec_stall_d", stall_d0, !v.fetch && t < 4);
      if (t == 1) begin
        chk32("vec_mem_addr", mem_addr0, v.addr);
        chk1("vec_mem_we", mem_we0, v.we && !v.fetch);
        chk32("vec_mem_wdata", mem_wdata0, v.fetch ? 32'h0 : v.wdata);
      end
      if (t == 4) begin
        if (v.fetch) chk32("vec_if_rdata", if_rdata0, v.exp_rdata);
        else         chk32("vec_d_rdata", d_rdata0, v.exp_rdata);
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk1("vec_back_idle", busy0, 1'b0);
  endtask

  // Random-phase model state
  int          idle_from, rdy_at, starve, grants, n_ifrdy;
  logic        own_d, e_we, e_en, win_d, e_drdy, e_irdy;
  logic [31:0] e_dat, e_addr, mdl_d_rdata, mdl_if_rdata;
  logic        p_if, p_d, p_dwe;
  logic [31:0] p_ifaddr, p_daddr, p_dwd;
  logic        order [6];
  logic        exp_order [6];

  initial begin
    reset = 1'b1;
    idle_inputs();
    mem0[32'h10] = 32'hDEADBEEF;
    mem0[32'h04] = 32'h8C010000;
    mem1[32'h30] = 32'hCAFEF00D;
    vecs[0] = '{fetch: 1'b0, we: 1'b0, addr: 32'h10, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
    vecs[1] = '{fetch: 1'b0, we: 1'b1, addr: 32'h20, wdata: 32'h12345678, exp_rdata: 32'hDEADBEEF};
    vecs[2] = '{fetch: 1'b1, we: 1'b0, addr: 32'h04, wdata: 32'h0,        exp_rdata: 32'h8C010000};
    vecs[3] = '{fetch: 1'b0, we: 1'b0, addr: 32'h20, wdata: 32'h0,        exp_rdata: 32'h12345678};
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    do_reset();
    @(negedge clk);
    chk1("rst_mem_en", mem_en0, 1'b0);
    chk1("rst_mem_we", mem_we0, 1'b0);
    chk32("rst_mem_addr", mem_addr0, 32'h0);
    chk32("rst_mem_wdata", mem_wdata0, 32'h0);
    chk32("rst_if_rdata", if_rdata0, 32'h0);
    chk32("rst_d_rdata", d_rdata0, 32'h0);
    chk1("rst_if_ready", if_ready0, 1'b0);
    chk1("rst_d_ready", d_ready0, 1'b0);
    chk1("rst_busy", busy0, 1'b0);
    chk1("rst_busy_lat1", busy1, 1'b0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Both requesters held: grant order D, D, IF repeating.
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    grants = 0;
    n_ifrdy = 0;
    for (int c = 0; c < 80 && grants < 6; c++) begin
      @(negedge clk);
      if (if_ready0) n_ifrdy++;
      if (mem_en0) begin
        order[grants] = (mem_addr0 == 32'h200);
        grants++;
      end
    end
    chk32("starve_grant_count", 32'(grants), 32'd6);
    for (int i = 0; i < 6; i++) chk1("starve_grant_order", order[i], exp_order[i]);
    chk32("starve_if_ready_count", 32'(n_ifrdy), 32'd1);

    // Reset during WAIT abandons the access.
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    for (int t = 0; t < 3; t++) @(negedge clk);
    reset = 1'b1;
    d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("rwait_mem_en", mem_en0, 1'b0);
    chk32("rwait_mem_addr", mem_addr0, 32'h0);
    chk32("rwait_d_rdata", d_rdata0, 32'h0);
    chk1("rwait_busy", busy0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      chk1("rwait_no_ready", d_ready0, 1'b0);
      chk1("rwait_no_issue", mem_en0, 1'b0);
      @(negedge clk);
    end
    run_vec(vecs[0]);

    // LATENCY=1 instance: ready one cycle earlier; the 2-cycle instance still completes after req drops.
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk1("lat1_mem_en", mem_en1, t == 1);
      chk1("lat1_d_ready", d_ready1, t == 3);
      if (t == 3) chk32("lat1_d_rdata", d_rdata1, 32'hCAFEF00D);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    chk1("lat2_ready_after_drop", d_ready0, 1'b1);
    chk1("lat1_no_reissue", mem_en1, 1'b0);

    // Random traffic against a transaction-level model.
    do_reset();
    idle_from = 0; rdy_at = -1; starve = 0; own_d = 1'b0; e_we = 1'b0;
    e_dat = '0; e_addr = '0; mdl_d_rdata = '0; mdl_if_rdata = '0;
    p_if = 1'b0; p_d = 1'b0; p_dwe = 1'b0; p_ifaddr = '0; p_daddr = '0; p_dwd = '0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      e_en = (n - 1 >= idle_from) && (p_if || p_d);
      if (e_en) begin
        win_d = p_d && !(p_if && starve == SMAX);
        if (win_d && p_if) starve = (starve + 1 > SMAX) ? SMAX : starve + 1;
        else               starve = 0;
        own_d  = win_d;
        e_addr = win_d ? p_daddr : p_ifaddr;
        e_we   = win_d && p_dwe;
        e_dat  = rd0(e_addr);
        rdy_at    = n + LAT + 1;
        idle_from = n + LAT + 2;
      end
      chk1("rnd_mem_en", mem_en0, e_en);
      if (e_en) begin
        chk32("rnd_mem_addr", mem_addr0, e_addr);
        chk1("rnd_mem_we", mem_we0, e_we);
        chk32("rnd_mem_wdata", mem_wdata0, own_d ? p_dwd : 32'h0);
      end
      e_drdy = (n == rdy_at) && own_d;
      e_irdy = (n == rdy_at) && !own_d;
      if (e_drdy && !e_we) mdl_d_rdata = e_dat;
      if (e_irdy)          mdl_if_rdata = e_dat;
      chk1("rnd_d_ready", d_ready0, e_drdy);
      chk1("rnd_if_ready", if_ready0, e_irdy);
      chk32("rnd_d_rdata", d_rdata0, mdl_d_rdata);
      chk32("rnd_if_rdata", if_rdata0, mdl_if_rdata);
      chk1("rnd_busy", busy0, n < idle_from);
      chk1("rnd_stall_d", stall_d0, d_req && !e_drdy);
      chk1("rnd_stall_if", stall_if0, if_req && !e_irdy);
      p_if = if_req; p_d = d_req; p_dwe = d_we;
      p_ifaddr = if_addr; p_daddr = d_addr; p_dwd = d_wdata;
      @(posedge clk); #1;
      if (!d_req || d_ready0) begin
        d_req = ($urandom_range(0, 3) != 0);
        d_we = $urandom_range(0, 1) == 1;
        d_addr = 32'($urandom_range(0, 15)) << 2;
        d_wdata = $urandom;
      end
      if (!if_req || if_ready0) begin
        if_req = ($urandom_range(0, 2) != 0);
        if_addr = 32'($urandom_range(0, 15)) << 2;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
